mem_arbiter: RTL and testbench

// - Two-master controller for the single-port async-control RAM (clk/addr/data/ce_n/we_n/oe_n/bw).
// - Arbitrates the RAM between m0 (D-cache/data side) and m1 (I-cache/refill side).
// - Sequences the ce_n/oe_n/we_n strobes and owns the tri-state data bus.
// - Runs single-word or line-burst transfers.

---
 rtl/mem_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-master controller for a single-port RAM with asynchronous control
//   strobes. Master m0 (data side) and master m1 (instruction/refill side)
//   share the RAM. The controller arbitrates between them, sequences the
//   ce_n/oe_n/we_n strobes, owns the tri-state data bus and runs
//   single-word or line-burst transfers.
//
//   Per beat: LOAD (1 cycle) -> ACCESS (ACCESS_CYCLES cycles) -> RECOVER
//   (1 cycle), so each beat takes ACCESS_CYCLES+2 cycles.
//
// Parameters
//   ACCESS_CYCLES  cycles ram_ce_n is held low per word (1..15)
//   LINE_WORDS     words per burst (power of 2, 2..16)
//
// Configuration macro
//   ARB_RR_EN      defined: round-robin arbitration on simultaneous requests
//                  undefined: fixed priority, m0 wins every tie
//
// Ports
//   clk, reset                synchronous active-high reset
//   mN_req/we/bw/burst        master request and transfer attributes (N=0,1)
//   mN_addr, mN_wdata         byte address, write data for the current beat
//   mN_gnt, mN_ack, mN_done   request accepted / beat complete / last beat
//   mN_rdata                  read word, valid while mN_ack=1, held otherwise
//   ram_addr, ram_data        RAM address and bidirectional data bus
//   ram_ce_n/we_n/oe_n        active-low RAM strobes
//   ram_bw                    RAM word/byte select
module mem_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int LINE_WORDS    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic        m0_bw,
    input  logic        m0_burst,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_ack,
    output logic        m0_done,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_bw,
    input  logic        m1_burst,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_ack,
    output logic        m1_done,
    output logic [31:0] m1_rdata,
    output logic [31:0] ram_addr,
    inout  wire  [31:0] ram_data,
    output logic        ram_ce_n,
    output logic        ram_we_n,
    output logic        ram_oe_n,
    output logic        ram_bw
);

    localparam int                BEAT_W    = $clog2(LINE_WORDS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [3:0]        ACC_LAST  = 4'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ACCESS,
        S_RECOVER
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic              r_owner;
    logic              r_we;
    logic              r_bw;
    logic              r_burst;
    logic [31:0]       r_base;
    logic [31:0]       r_wdata;
    logic [31:0]       r_addr;
    logic [31:0]       r_rdata0;
    logic [31:0]       r_rdata1;
    logic [BEAT_W-1:0] r_beat;
    logic [3:0]        r_accCnt;

    logic              w_anyReq;
    logic              w_pick1;
    logic              w_lastBeat;
    logic              w_accDone;

    assign w_anyReq   = m0_req | m1_req;
    assign w_lastBeat = ~r_burst | (r_beat == LAST_BEAT);
    assign w_accDone  = (r_accCnt == ACC_LAST);

    // Arbitration decision, only used while idle. w_pick1 selects m1.
`ifdef ARB_RR_EN
    // Last-grant pointer: on a tie the master not granted last time wins.
    // It resets to m1 so m0 takes the first tie.
    logic r_lastGnt;

    assign w_pick1 = m1_req & (~m0_req | ~r_lastGnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lastGnt <= 1'b1;
        end else if (r_state == S_IDLE && w_anyReq) begin
            r_lastGnt <= w_pick1;
        end
    end
`else
    assign w_pick1 = m1_req & ~m0_req;
`endif

    assign ram_addr = r_addr;
    assign ram_bw   = r_bw;
    assign m0_rdata = r_rdata0;
    assign m1_rdata = r_rdata1;

    // The bus is driven only while a write is in ACCESS; the RAM owns it
    // during reads and nobody drives it otherwise.
    assign ram_data = (r_state == S_ACCESS && r_we) ? r_wdata : 'z;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and strobe/handshake decode. gnt is combinational so the
    // winner sees it in the same cycle it is arbitrated. Handshakes are
    // forced low while reset is asserted so an interrupted transfer never
    // reports a beat.
    always_comb begin
        w_nextState = r_state;
        m0_gnt      = 1'b0;
        m1_gnt      = 1'b0;
        m0_ack      = 1'b0;
        m1_ack      = 1'b0;
        m0_done     = 1'b0;
        m1_done     = 1'b0;
        ram_ce_n    = 1'b1;
        ram_we_n    = 1'b1;
        ram_oe_n    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_anyReq) begin
                    w_nextState = S_LOAD;
                    m0_gnt      = ~w_pick1;
                    m1_gnt      = w_pick1;
                end
            end
            S_LOAD: begin
                w_nextState = S_ACCESS;
            end
            S_ACCESS: begin
                ram_ce_n = 1'b0;
                ram_we_n = ~r_we;
                ram_oe_n = r_we;
                if (w_accDone) begin
                    w_nextState = S_RECOVER;
                end
            end
            S_RECOVER: begin
                m0_ack      = ~r_owner;
                m1_ack      = r_owner;
                m0_done     = ~r_owner & w_lastBeat;
                m1_done     = r_owner & w_lastBeat;
                w_nextState = w_lastBeat ? S_IDLE : S_LOAD;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
        if (reset) begin
            m0_gnt  = 1'b0;
            m1_gnt  = 1'b0;
            m0_ack  = 1'b0;
            m1_ack  = 1'b0;
            m0_done = 1'b0;
            m1_done = 1'b0;
        end
    end

    // Transfer datapath. Attributes are captured at grant; a byte access
    // never bursts. Each LOAD captures the owner's current wdata and the
    // beat address; bursts wrap inside the line by replacing only the
    // word-index bits. Read data is captured on the last ACCESS cycle into
    // the owner's rdata register; the other master's register is untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner  <= 1'b0;
            r_we     <= 1'b0;
            r_bw     <= 1'b1;
            r_burst  <= 1'b0;
            r_base   <= '0;
            r_wdata  <= '0;
            r_addr   <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_beat   <= '0;
            r_accCnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_anyReq) begin
                        r_owner <= w_pick1;
                        r_we    <= w_pick1 ? m1_we   : m0_we;
                        r_bw    <= w_pick1 ? m1_bw   : m0_bw;
                        r_base  <= w_pick1 ? m1_addr : m0_addr;
                        r_burst <= w_pick1 ? (m1_burst & m1_bw) : (m0_burst & m0_bw);
                        r_beat  <= '0;
                    end
                end
                S_LOAD: begin
                    r_wdata  <= r_owner ? m1_wdata : m0_wdata;
                    r_addr   <= r_burst ? {r_base[31:BEAT_W+2], r_beat, 2'b00} : r_base;
                    r_accCnt <= '0;
                end
                S_ACCESS: begin
                    r_accCnt <= r_accCnt + 4'd1;
                    if (w_accDone && !r_we) begin
                        if (r_owner) begin
                            r_rdata1 <= ram_data;
                        end else begin
                            r_rdata0 <= ram_data;
                        end
                    end
                end
                S_RECOVER: begin
                    r_beat <= r_beat + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Bench for mem_arbiter. A behavioural RAM sits on the bus; a separate
//   reference memory plus per-beat address/timing arithmetic predicts every
//   grant, strobe window, bus value, ack/done pulse and read word.
//   While ce_n is high the bench holds a known idle pattern on the bus so
//   that any stray drive from the controller corrupts it visibly.
module tb_mem_arbiter;

    localparam int          ACC      = 2;
    localparam int          LW       = 4;
    localparam int          PER      = 10;
    localparam logic [31:0] BUS_IDLE = 32'hA5A5_A5A5;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req   = '0;
    logic [1:0]  we    = '0;
    logic [1:0]  bw    = '1;
    logic [1:0]  burst = '0;
    logic [31:0] addrIn [2];
    logic [31:0] wdIn   [2];
    wire  [1:0]  gnt;
    wire  [1:0]  ack;
    wire  [1:0]  done;
    wire  [31:0] rd0;
    wire  [31:0] rd1;
    wire  [31:0] ram_addr;
    wire  [31:0] ram_data;
    wire         ram_ce_n;
    wire         ram_we_n;
    wire         ram_oe_n;
    wire         ram_bw;

    logic [31:0] ramOut = '0;
    logic        tbDrv;
    logic [31:0] mem    [logic [29:0]];
    logic [31:0] refMem [logic [29:0]];
    logic [31:0] lastRd [2];
    int          checks = 0;
    int          errors = 0;

    mem_arbiter #(.ACCESS_CYCLES(ACC), .LINE_WORDS(LW)) dut (
        .clk(clk), .reset(reset),
        .m0_req(req[0]), .m0_we(we[0]), .m0_bw(bw[0]), .m0_burst(burst[0]),
        .m0_addr(addrIn[0]), .m0_wdata(wdIn[0]),
        .m0_gnt(gnt[0]), .m0_ack(ack[0]), .m0_done(done[0]), .m0_rdata(rd0),
        .m1_req(req[1]), .m1_we(we[1]), .m1_bw(bw[1]), .m1_burst(burst[1]),
        .m1_addr(addrIn[1]), .m1_wdata(wdIn[1]),
        .m1_gnt(gnt[1]), .m1_ack(ack[1]), .m1_done(done[1]), .m1_rdata(rd1),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_ce_n(ram_ce_n),
        .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n), .ram_bw(ram_bw)
    );

    always #(PER / 2) clk = ~clk;

    // Bench-side bus drive: idle pattern while deselected, RAM word during reads.
    assign tbDrv    = ram_ce_n | (~ram_oe_n & ram_we_n);
    assign ram_data = tbDrv ? (ram_ce_n ? BUS_IDLE : ramOut) : 32'hz;

    // Behavioural RAM: writes and read lookups happen mid-cycle while the
    // strobes are stable.
    initial begin
        logic [31:0] w;
        int          lane;
        forever begin
            @(negedge clk);
            if (!ram_ce_n && !ram_we_n) begin
                w = mem.exists(ram_addr[31:2]) ? mem[ram_addr[31:2]] : 32'h0;
                if (ram_bw) begin
                    w = ram_data;
                end else begin
                    lane = int'(ram_addr[1:0]);
                    w[8*lane +: 8] = ram_data[8*lane +: 8];
                end
                mem[ram_addr[31:2]] = w;
            end
            ramOut = mem.exists(ram_addr[31:2]) ? mem[ram_addr[31:2]] : 32'h0;
        end
    end

    // Watchdog so a hung handshake can never stall the run.
    initial begin
        #(PER * 20000);
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] getRd(input int m);
        return (m != 0) ? rd1 : rd0;
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] a);
        return refMem.exists(a[31:2]) ? refMem[a[31:2]] : 32'h0;
    endfunction

    function automatic void refWrite(input logic [31:0] a, input logic [31:0] d, input logic b);
        logic [31:0] w;
        int          lane;
        w = refRead(a);
        if (b) begin
            w = d;
        end else begin
            lane = int'(a[1:0]);
            w[8*lane +: 8] = d[8*lane +: 8];
        end
        refMem[a[31:2]] = w;
    endfunction

    function automatic void preload(input logic [31:0] a, input logic [31:0] d);
        mem[a[31:2]]    = d;
        refMem[a[31:2]] = d;
    endfunction

    // Follows one transfer of master m whose request is already raised:
    // waits for its grant, then checks every cycle of every beat. With
    // abortAfter >= 0, reset is pulsed right after that many acks.
    task automatic runOwned(input int m, input int abortAfter, output int waitCyc);
        int          o;
        int          nBeats;
        int          cyc;
        int          beat;
        int          lowCnt;
        bit          aborted;
        logic        effBurst;
        logic [31:0] expAddr;
        logic [31:0] lineMask;
        logic [31:0] expRd;
        o        = 1 - m;
        effBurst = burst[m] & bw[m];
        nBeats   = effBurst ? LW : 1;
        lineMask = 32'(LW * 4 - 1);
        waitCyc  = 0;
        aborted  = 0;
        #1;
        while (!gnt[m] && waitCyc < 50) begin
            @(negedge clk);
            #1;
            waitCyc++;
        end
        checkOutput($sformatf("m%0d gnt", m), 32'(gnt[m]), 32'd1);
        checkOutput($sformatf("m%0d loser gnt", o), 32'(gnt[o]), 32'd0);
        cyc    = 0;
        beat   = 0;
        lowCnt = 0;
        while (beat < nBeats && cyc < 20 * nBeats + 20) begin
            @(negedge clk);
            req[m] = 1'b0;
            cyc++;
            #1;
            expAddr = effBurst ? ((addrIn[m] & ~lineMask) | ((addrIn[m] + 32'(4 * beat)) & lineMask))
                               : addrIn[m];
            if (!ram_ce_n) begin
                lowCnt++;
                checkOutput("ram_addr", ram_addr, expAddr);
                checkOutput("ram_bw", 32'(ram_bw), 32'(bw[m]));
                checkOutput("ram_we_n", 32'(ram_we_n), 32'(!we[m]));
                checkOutput("ram_oe_n", 32'(ram_oe_n), 32'(we[m]));
                if (we[m]) begin
                    checkOutput("write bus", ram_data, wdIn[m]);
                end
            end else begin
                checkOutput("idle strobes", {30'd0, ram_we_n, ram_oe_n}, 32'd3);
                checkOutput("bus released", ram_data, BUS_IDLE);
            end
            checkOutput("non-owner handshakes", {29'd0, gnt[o], ack[o], done[o]}, 32'd0);
            checkOutput("done without ack", 32'(done[m] & !ack[m]), 32'd0);
            if (ack[m]) begin
                checkOutput("ack cycle", cyc, (ACC + 2) * (beat + 1));
                checkOutput("ce_n low cycles", lowCnt, ACC);
                checkOutput("done", 32'(done[m]), 32'(beat == nBeats - 1));
                if (!we[m]) begin
                    expRd = refRead(expAddr);
                    checkOutput("rdata", getRd(m), expRd);
                    lastRd[m] = expRd;
                end else begin
                    refWrite(expAddr, wdIn[m], bw[m]);
                end
                checkOutput("non-owner rdata held", getRd(o), lastRd[o]);
                wdIn[m] = wdIn[m] + 32'h0101_0101;
                beat++;
                lowCnt = 0;
                if (beat == abortAfter) begin
                    aborted = 1;
                    break;
                end
            end
        end
        if (aborted) begin
            reset = 1'b1;
            @(negedge clk);
            #1;
            checkOutput("reset strobes", {29'd0, ram_ce_n, ram_we_n, ram_oe_n}, 32'd7);
            checkOutput("reset bus", ram_data, BUS_IDLE);
            checkOutput("reset ram_addr", ram_addr, 32'd0);
            checkOutput("reset ram_bw", 32'(ram_bw), 32'd1);
            checkOutput("reset rdata0", rd0, 32'd0);
            checkOutput("reset rdata1", rd1, 32'd0);
            checkOutput("reset handshakes", {26'd0, gnt, ack, done}, 32'd0);
            reset     = 1'b0;
            lastRd[0] = '0;
            lastRd[1] = '0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                #1;
                checkOutput("no ack after reset", {26'd0, gnt, ack, done}, 32'd0);
            end
        end else begin
            checkOutput("beats completed", beat, nBeats);
        end
    endtask

    task automatic applyStimulus(input int m, input logic w, input logic b, input logic bu,
                                 input logic [31:0] a, input logic [31:0] d, input int abortAfter);
        int wc;
        we[m]     = w;
        bw[m]     = b;
        burst[m]  = bu;
        addrIn[m] = a;
        wdIn[m]   = d;
        req[m]    = 1'b1;
        runOwned(m, abortAfter, wc);
    endtask

    initial begin
        int          wc;
        int          first;
        int          m;
        logic        rw;
        logic        rb;
        logic        rbu;
        logic [31:0] a;

        addrIn[0] = '0;
        addrIn[1] = '0;
        wdIn[0]   = '0;
        wdIn[1]   = '0;
        lastRd[0] = '0;
        lastRd[1] = '0;

        $display("[TB] reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("init strobes", {29'd0, ram_ce_n, ram_we_n, ram_oe_n}, 32'd7);
        checkOutput("init ram_bw", 32'(ram_bw), 32'd1);
        checkOutput("init ram_addr", ram_addr, 32'd0);
        checkOutput("init bus", ram_data, BUS_IDLE);
        checkOutput("init rdata0", rd0, 32'd0);
        checkOutput("init rdata1", rd1, 32'd0);
        checkOutput("init handshakes", {26'd0, gnt, ack, done}, 32'd0);

        $display("[TB] directed transfers");
        preload(32'h1001_0000, 32'h3C01_1001);
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 32'h1001_0000, 32'h0, -1);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF, -1);
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 32'h1001_0004, 32'h0, -1);
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 32'h1001_0006, 32'h1122_3344, -1);
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 32'h1001_0004, 32'h0, -1);

        for (int i = 0; i < LW; i++) begin
            preload(32'h0040_0000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
        end
        applyStimulus(1, 1'b0, 1'b1, 1'b1, 32'h0040_0000, 32'h0, -1);
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h0040_0010, 32'h5000_0001, -1);
        applyStimulus(1, 1'b0, 1'b1, 1'b1, 32'h0040_0010, 32'h0, -1);

        $display("[TB] contention");
        we[1] = 1'b0; bw[1] = 1'b1; burst[1] = 1'b0; addrIn[1] = 32'h0040_0004; req[1] = 1'b1;
        we[0] = 1'b0; bw[0] = 1'b1; burst[0] = 1'b0; addrIn[0] = 32'h1001_0000; req[0] = 1'b1;
        runOwned(0, -1, wc);
        addrIn[0] = 32'h1001_0004;
        req[0]    = 1'b1;
`ifdef ARB_RR_EN
        first = 1;
`else
        first = 0;
`endif
        runOwned(first, -1, wc);
        checkOutput("tie2 grant gap", wc, 1);
        runOwned(1 - first, -1, wc);
        checkOutput("held req grant gap", wc, 1);

        $display("[TB] reset mid-burst");
        applyStimulus(1, 1'b0, 1'b1, 1'b1, 32'h0040_0000, 32'h0, 2);
        applyStimulus(1, 1'b0, 1'b1, 1'b1, 32'h0040_0000, 32'h0, -1);

        $display("[TB] random transfers");
        for (int i = 0; i < 30; i++) begin
            m   = int'($urandom_range(0, 1));
            rw  = 1'($urandom_range(0, 1));
            rb  = 1'($urandom_range(0, 1));
            rbu = 1'($urandom_range(0, 1));
            a   = 32'h2000_0000 | (32'($urandom_range(0, 15)) << 2);
            if (!rb) begin
                a = a | 32'($urandom_range(0, 3));
            end else if (rbu) begin
                a = a & ~32'(LW * 4 - 1);
            end
            applyStimulus(m, rw, rb, rbu, a, $urandom(), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
